// File: rtl/comm_master_n.sv
// comm_master_n: UART command master that sends CMD_BYTES 8N1 frames (MSB byte first),
// then optionally collects RESP_BYTES response bytes; `define CMD_CHKSUM_EN appends ~sum byte.
module comm_master_n #(
  parameter int unsigned CMD_BYTES   = 2,
  parameter int unsigned RESP_BYTES  = 1,
  parameter int unsigned BAUD_DIV    = 2604,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             snd_cmd,
  input  logic [8*CMD_BYTES-1:0]                           cmd,
  input  logic                                             RX,
  output logic                                             TX,
  output logic                                             busy,
  output logic                                             cmd_cmplt,
  output logic [((RESP_BYTES == 0) ? 1 : 8*RESP_BYTES)-1:0] resp,
  output logic                                             resp_vld,
  output logic                                             timeout,
  output logic                                             frm_err
);

`ifdef CMD_CHKSUM_EN
  localparam int unsigned NB = CMD_BYTES + 1;
`else
  localparam int unsigned NB = CMD_BYTES;
`endif
  localparam int unsigned RPW = (RESP_BYTES == 0) ? 1 : 8*RESP_BYTES;
  localparam int unsigned RSW = (RESP_BYTES == 0) ? 8 : 8*RESP_BYTES;
  localparam int unsigned BDW = $clog2(BAUD_DIV);
  localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned RCW = (RESP_BYTES > 1) ? $clog2(RESP_BYTES) : 1;
  localparam int unsigned TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             tx_q, tx_d;
  logic             cmd_cmplt_q, cmd_cmplt_d;
  logic [RPW-1:0]   resp_q, resp_d;
  logic             resp_vld_q, resp_vld_d;
  logic             timeout_q, timeout_d;
  logic             frm_err_q, frm_err_d;

  logic [8*NB-1:0]  tx_sr_q, tx_sr_d;
  logic [BDW-1:0]   tx_baud_q, tx_baud_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [BCW-1:0]   tx_byte_q, tx_byte_d;
  logic             tx_done_q, tx_done_d;

  logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
  logic             rx_act_q, rx_act_d;
  logic [BDW-1:0]   rx_baud_q, rx_baud_d;
  logic [3:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic [RCW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [RSW-1:0]   resp_sr_q, resp_sr_d;
  logic [TCW-1:0]   tmo_q, tmo_d;

  logic [8*NB-1:0]  tx_load;
  logic [7:0]       cur_byte;
  logic [RSW-1:0]   resp_sr_nxt;
  logic             rx_done, rx_bad;

`ifdef CMD_CHKSUM_EN
  logic [7:0] chk_sum;
  always_comb begin
    chk_sum = '0;
    for (int unsigned i = 0; i < CMD_BYTES; i++) chk_sum = chk_sum + cmd[8*i +: 8];
    tx_load = {cmd, ~chk_sum};
  end
`else
  assign tx_load = cmd;
`endif

  assign cur_byte    = tx_sr_q[8*NB-1 -: 8];
  assign resp_sr_nxt = (resp_sr_q << 8) | RSW'(rx_byte_q);

  always_comb begin
    state_d     = state_q;
    busy_d      = (state_q != IDLE);
    tx_d        = tx_q;
    cmd_cmplt_d = 1'b0;
    resp_d      = resp_q;
    resp_vld_d  = 1'b0;
    timeout_d   = 1'b0;
    frm_err_d   = 1'b0;
    tx_sr_d     = tx_sr_q;
    tx_baud_d   = tx_baud_q;
    tx_bit_d    = tx_bit_q;
    tx_byte_d   = tx_byte_q;
    tx_done_d   = tx_done_q;
    rx_s1_d     = RX;
    rx_s2_d     = rx_s1_q;
    rx_s3_d     = rx_s2_q;
    rx_act_d    = rx_act_q;
    rx_baud_d   = rx_baud_q;
    rx_bit_d    = rx_bit_q;
    rx_byte_d   = rx_byte_q;
    rx_cnt_d    = rx_cnt_q;
    resp_sr_d   = resp_sr_q;
    tmo_d       = tmo_q;
    rx_done     = 1'b0;
    rx_bad      = 1'b0;

    case (state_q)
      IDLE: begin
        if (snd_cmd && !busy_q) begin
          state_d   = SEND;
          tx_sr_d   = tx_load;
          tx_baud_d = '0;
          tx_bit_d  = '0;
          tx_byte_d = '0;
          tx_done_d = 1'b0;
          tx_d      = 1'b0;
        end
      end

      SEND: begin
        // tx_done_q spaces cmd_cmplt one cycle past the end of the last stop bit
        if (tx_done_q) begin
          cmd_cmplt_d = 1'b1;
          tmo_d       = '0;
          rx_act_d    = 1'b0;
          rx_cnt_d    = '0;
          resp_sr_d   = '0;
          state_d     = (RESP_BYTES == 0) ? IDLE : WAIT_RESP;
        end else if (tx_baud_q == BDW'(BAUD_DIV - 1)) begin
          tx_baud_d = '0;
          if (tx_bit_q == 4'd9) begin
            if (tx_byte_q == BCW'(NB - 1)) begin
              tx_done_d = 1'b1;
            end else begin
              tx_byte_d = tx_byte_q + 1'b1;
              tx_sr_d   = tx_sr_q << 8;
              tx_bit_d  = '0;
              tx_d      = 1'b0;
            end
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_d     = (tx_bit_q == 4'd8) ? 1'b1 : cur_byte[tx_bit_q[2:0]];
          end
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end

      WAIT_RESP: begin
        if (!rx_act_q) begin
          if (rx_s3_q && !rx_s2_q) begin
            rx_act_d  = 1'b1;
            rx_baud_d = '0;
            rx_bit_d  = '0;
          end
        end else if (rx_bit_q == 4'd0) begin
          if (rx_baud_q == BDW'(BAUD_DIV/2 - 1)) begin
            rx_baud_d = '0;
            if (rx_s2_q) rx_act_d = 1'b0;
            else         rx_bit_d = 4'd1;
          end else begin
            rx_baud_d = rx_baud_q + 1'b1;
          end
        end else if (rx_baud_q == BDW'(BAUD_DIV - 1)) begin
          rx_baud_d = '0;
          if (rx_bit_q != 4'd9) begin
            rx_byte_d = {rx_s2_q, rx_byte_q[7:1]};
            rx_bit_d  = rx_bit_q + 1'b1;
          end else begin
            rx_act_d = 1'b0;
            if (!rx_s2_q) begin
              rx_bad = 1'b1;
            end else if (rx_cnt_q == RCW'(RESP_BYTES - 1)) begin
              rx_done = 1'b1;
            end else begin
              rx_cnt_d  = rx_cnt_q + 1'b1;
              resp_sr_d = resp_sr_nxt;
            end
          end
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end

        // completion outranks an expiring window in the same cycle
        if (rx_done) begin
          resp_d     = resp_sr_nxt[RPW-1:0];
          resp_vld_d = 1'b1;
          state_d    = IDLE;
        end else if (rx_bad) begin
          frm_err_d = 1'b1;
          state_d   = IDLE;
        end else if (tmo_q == TCW'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      tx_q        <= 1'b1;
      cmd_cmplt_q <= 1'b0;
      resp_q      <= '0;
      resp_vld_q  <= 1'b0;
      timeout_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      tx_sr_q     <= '0;
      tx_baud_q   <= '0;
      tx_bit_q    <= '0;
      tx_byte_q   <= '0;
      tx_done_q   <= 1'b0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      rx_act_q    <= 1'b0;
      rx_baud_q   <= '0;
      rx_bit_q    <= '0;
      rx_byte_q   <= '0;
      rx_cnt_q    <= '0;
      resp_sr_q   <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      tx_q        <= tx_d;
      cmd_cmplt_q <= cmd_cmplt_d;
      resp_q      <= resp_d;
      resp_vld_q  <= resp_vld_d;
      timeout_q   <= timeout_d;
      frm_err_q   <= frm_err_d;
      tx_sr_q     <= tx_sr_d;
      tx_baud_q   <= tx_baud_d;
      tx_bit_q    <= tx_bit_d;
      tx_byte_q   <= tx_byte_d;
      tx_done_q   <= tx_done_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_s3_q     <= rx_s3_d;
      rx_act_q    <= rx_act_d;
      rx_baud_q   <= rx_baud_d;
      rx_bit_q    <= rx_bit_d;
      rx_byte_q   <= rx_byte_d;
      rx_cnt_q    <= rx_cnt_d;
      resp_sr_q   <= resp_sr_d;
      tmo_q       <= tmo_d;
    end
  end

  assign TX        = tx_q;
  assign busy      = busy_q;
  assign cmd_cmplt = cmd_cmplt_q;
  assign resp      = resp_q;
  assign resp_vld  = resp_vld_q;
  assign timeout   = timeout_q;
  assign frm_err   = frm_err_q;

endmodule
